// File: rtl/prbs_burst_ctrl.sv
// Command-driven PRBS burst generator: one shared LFSR with a selectable polynomial
// streams a fixed number of DATA_W-bit beats over a valid/ready port.
module prbs_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [30:0]       cmd_seed,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [30:0] len_mask(input logic [1:0] mode);
    case (mode)
      2'd0:    len_mask = 31'h0000_007F;
      2'd1:    len_mask = 31'h0000_7FFF;
      2'd2:    len_mask = 31'h007F_FFFF;
      default: len_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic step_bit(input logic [1:0] mode, input logic [30:0] s);
    case (mode)
      2'd0:    step_bit = s[6]  ^ s[5];
      2'd1:    step_bit = s[14] ^ s[13];
      2'd2:    step_bit = s[22] ^ s[17];
      default: step_bit = s[30] ^ s[27];
    endcase
  endfunction

  // An all-zero register would never leave zero, so substitute all-ones.
  function automatic logic [30:0] seed_init(input logic [1:0] mode, input logic [30:0] seed);
    logic [30:0] m;
    m = seed & len_mask(mode);
    seed_init = (m == 31'd0) ? len_mask(mode) : m;
  endfunction

  // Returns {beat data, LFSR state after DATA_W steps}.
  function automatic logic [DATA_W+30:0] gen_beat(input logic [1:0] mode, input logic [30:0] s);
    logic [30:0]       st;
    logic [DATA_W-1:0] d;
    logic              nb;
    st = s;
    d  = {DATA_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      nb   = step_bit(mode, st);
      d[i] = nb;
      st   = {st[29:0], nb} & len_mask(mode);
    end
    gen_beat = {d, st};
  endfunction

  logic [1:0]        state_q, state_d;
  logic [30:0]       lfsr_q, lfsr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              aborted_q, aborted_d;
  logic              fire_s;
  logic [DATA_W-1:0] beat_data_s;
  logic [30:0]       beat_lfsr_s;

  assign fire_s = valid_q & out_ready;

  always_comb begin
    beat_data_s = {DATA_W{1'b0}};
    beat_lfsr_s = 31'd0;
    if (state_q == ST_IDLE) begin
      {beat_data_s, beat_lfsr_s} = gen_beat(cmd_mode, seed_init(cmd_mode, cmd_seed));
    end else begin
      {beat_data_s, beat_lfsr_s} = gen_beat(mode_q, lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= 31'd0;
      data_q    <= {DATA_W{1'b0}};
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= {LEN_W{1'b0}};
      mode_q    <= 2'd0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = (cmd_len == {LEN_W{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ((fire_s && last_q) || abort) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // cnt_q holds the beats still to come after the one presented on out_data.
  always_comb begin
    lfsr_d    = lfsr_q;
    data_d    = data_q;
    last_d    = last_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: begin
        aborted_d = 1'b0;
        if (cmd_valid && (cmd_len != {LEN_W{1'b0}})) begin
          mode_d  = cmd_mode;
          lfsr_d  = beat_lfsr_s;
          data_d  = beat_data_s;
          valid_d = 1'b1;
          last_d  = (cmd_len == {{(LEN_W-1){1'b0}}, 1'b1});
          cnt_d   = cmd_len - {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (fire_s && last_q) begin
          valid_d   = 1'b0;
          last_d    = 1'b0;
          aborted_d = 1'b0;
        end else if (abort) begin
          valid_d   = 1'b0;
          last_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (fire_s) begin
          lfsr_d = beat_lfsr_s;
          data_d = beat_data_s;
          last_d = (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1});
          cnt_d  = (cnt_q != {LEN_W{1'b0}}) ? (cnt_q - {{(LEN_W-1){1'b0}}, 1'b1}) : cnt_q;
        end else begin
          valid_d = valid_q;
        end
      end
      ST_DONE: aborted_d = 1'b0;
      default: aborted_d = 1'b0;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_RUN:  busy      = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign aborted   = aborted_q;

endmodule
